// File: rtl/jump_controller.sv
// Player jump arc generator: synchronises the raw jump key and steps a
// rise / apex-hold / fall height profile once per enabled frame tick.
module jump_controller #(
  parameter int MAX_HEIGHT = 40,
  parameter int RISE_STEP  = 4,
  parameter int FALL_STEP  = 2,
  parameter int APEX_HOLD  = 4,
  parameter int BASE_Y     = 88
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic       frame_tick,
  input  logic       jump_key,
  output logic [5:0] height,
  output logic [6:0] y_top,
  output logic       ground,
  output logic       airborne,
  output logic       jump_start,
  output logic       landed
);

  localparam logic [1:0] S_GROUND = 2'd0;
  localparam logic [1:0] S_RISE   = 2'd1;
  localparam logic [1:0] S_APEX   = 2'd2;
  localparam logic [1:0] S_FALL   = 2'd3;

  localparam int         HW     = $clog2(APEX_HOLD + 1);
  localparam logic [6:0] MAX7   = 7'(MAX_HEIGHT);
  localparam logic [6:0] RISE7  = 7'(RISE_STEP);
  localparam logic [5:0] FALL6  = 6'(FALL_STEP);
  localparam logic [6:0] BASE7  = 7'(BASE_Y);
  localparam logic [5:0] TAKEOFF_H = (RISE_STEP < MAX_HEIGHT) ? 6'(RISE_STEP) : 6'(MAX_HEIGHT);

  logic          sync1_q, sync2_q, prev_q;
  logic          jreq_q, jreq_d;
  logic [1:0]    state_q, state_d;
  logic [5:0]    height_q, height_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [6:0]    y_top_q, y_top_d;
  logic          ground_q, ground_d;
  logic          jstart_q, jstart_d;
  logic          landed_q, landed_d;
  logic          press, qual;
  logic [6:0]    rise_sum;

  // Key is active-low: a press is the synced level falling 1 -> 0.
  assign press    = prev_q & ~sync2_q;
  assign qual     = frame_tick & enable;
  assign rise_sum = {1'b0, height_q} + RISE7;

  always_comb begin
    state_d  = state_q;
    height_d = height_q;
    hold_d   = hold_q;
    jstart_d = 1'b0;
    landed_d = 1'b0;
    if (qual) begin
      case (state_q)
        S_GROUND: begin
          height_d = '0;
          if (jreq_q) begin
            state_d  = S_RISE;
            height_d = TAKEOFF_H;
            jstart_d = 1'b1;
          end
        end
        S_RISE: begin
          height_d = (rise_sum >= MAX7) ? MAX7[5:0] : rise_sum[5:0];
          if (rise_sum >= MAX7) begin
            state_d = S_APEX;
            hold_d  = HW'(APEX_HOLD);
          end
        end
        S_APEX: begin
          if (hold_q == HW'(1)) state_d = S_FALL;
          else                  hold_d  = hold_q - HW'(1);
        end
        default: begin
          height_d = (height_q > FALL6) ? height_q - FALL6 : 6'd0;
          if (height_q <= FALL6) begin
            state_d  = S_GROUND;
            landed_d = 1'b1;
          end
        end
      endcase
    end
  end

  // Requests never buffer across a jump; the takeoff tick consumes them and
  // a press arriving on that same tick is dropped.
  always_comb begin
    jreq_d = jreq_q;
    if (!enable || state_q != S_GROUND) jreq_d = 1'b0;
    else if (qual && jreq_q)            jreq_d = 1'b0;
    else if (press)                     jreq_d = 1'b1;
  end

  assign y_top_d  = BASE7 - {1'b0, height_d};
  assign ground_d = (state_d == S_GROUND);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      prev_q   <= 1'b1;
      jreq_q   <= 1'b0;
      state_q  <= S_GROUND;
      height_q <= '0;
      hold_q   <= '0;
      y_top_q  <= BASE7;
      ground_q <= 1'b1;
      jstart_q <= 1'b0;
      landed_q <= 1'b0;
    end else begin
      sync1_q  <= jump_key;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      jreq_q   <= jreq_d;
      state_q  <= state_d;
      height_q <= height_d;
      hold_q   <= hold_d;
      y_top_q  <= y_top_d;
      ground_q <= ground_d;
      jstart_q <= jstart_d;
      landed_q <= landed_d;
    end
  end

  assign height     = height_q;
  assign y_top      = y_top_q;
  assign ground     = ground_q;
  assign airborne   = ~ground_q;
  assign jump_start = jstart_q;
  assign landed     = landed_q;

endmodule

// File: tb/tb_jump_controller.sv
// Directed bench for jump_controller: default arc plus a 3/3-step instance
// sharing the same stimulus, airborne presses, pause, reset and tick races.
module tb_jump_controller;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b1;
  logic       frame_tick = 1'b0;
  logic       jump_key = 1'b1;
  logic [5:0] height, height2;
  logic [6:0] y_top, y_top2;
  logic       ground, ground2, airborne, airborne2;
  logic       jump_start, jump_start2, landed, landed2;

  int checks = 0;
  int errors = 0;
  int starts;

  jump_controller dut (
    .clk(clk), .resetn(resetn), .enable(enable), .frame_tick(frame_tick),
    .jump_key(jump_key), .height(height), .y_top(y_top), .ground(ground),
    .airborne(airborne), .jump_start(jump_start), .landed(landed)
  );

  jump_controller #(.RISE_STEP(3), .FALL_STEP(3)) dut2 (
    .clk(clk), .resetn(resetn), .enable(enable), .frame_tick(frame_tick),
    .jump_key(jump_key), .height(height2), .y_top(y_top2), .ground(ground2),
    .airborne(airborne2), .jump_start(jump_start2), .landed(landed2)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Tick is high for exactly one rising edge; outputs are read at the next negedge.
  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic press_key();
    @(negedge clk) jump_key = 1'b0;
    idle(4);
  endtask

  task automatic rel_key();
    @(negedge clk) jump_key = 1'b1;
    idle(4);
  endtask

  // Default arc: 4/tick to 40 (ticks 1..10), apex ticks 11..14, 2/tick down.
  function automatic int exp1(input int k);
    if (k <= 10) return 4 * k;
    if (k <= 14) return 40;
    return 40 - 2 * (k - 14);
  endfunction

  // 3/3 arc: 3..39 then 40 at tick 14, apex 15..18, 37..1 then 0 at tick 32.
  function automatic int exp2(input int k);
    int v;
    if (k <= 13) return 3 * k;
    if (k <= 18) return 40;
    v = 40 - 3 * (k - 18);
    return (v < 0) ? 0 : v;
  endfunction

  initial begin
    idle(2);
    chk("rst_height", height, 0);
    chk("rst_y_top", y_top, 88);
    chk("rst_ground", ground, 1);
    chk("rst_airborne", airborne, 0);
    chk("rst_jump_start", jump_start, 0);
    chk("rst_landed", landed, 0);
    chk("rst_height2", height2, 0);
    @(negedge clk) resetn = 1'b1;
    idle(2);

    repeat (3) begin
      tick();
      chk("idle_height", height, 0);
      chk("idle_ground", ground, 1);
      chk("idle_jump_start", jump_start, 0);
    end

    // Full arc on both instances.
    press_key();
    rel_key();
    for (int k = 1; k <= 34; k++) begin
      tick();
      chk($sformatf("arc_h_t%0d", k), height, exp1(k));
      chk($sformatf("arc_y_t%0d", k), y_top, 88 - exp1(k));
      chk($sformatf("arc_gnd_t%0d", k), ground, (exp1(k) == 0) ? 1 : 0);
      chk($sformatf("arc_start_t%0d", k), jump_start, (k == 1) ? 1 : 0);
      chk($sformatf("arc_land_t%0d", k), landed, (k == 34) ? 1 : 0);
      chk($sformatf("sat_h_t%0d", k), height2, exp2(k));
      chk($sformatf("sat_land_t%0d", k), landed2, (k == 32) ? 1 : 0);
    end
    idle(1);
    chk("pulse_end_land", landed, 0);
    chk("pulse_end_start", jump_start, 0);

    // Key held through the jump plus re-presses while rising and falling.
    starts = 0;
    press_key();
    for (int k = 1; k <= 34; k++) begin
      tick();
      starts += int'(jump_start);
      if (k == 3 || k == 20) begin
        rel_key();
        press_key();
      end
    end
    chk("held_starts", starts, 1);
    chk("held_land_h", height, 0);
    chk("held_landed", landed, 1);
    tick();
    chk("held_noretake_h", height, 0);
    chk("held_noretake_start", jump_start, 0);

    rel_key();
    press_key();
    rel_key();
    tick();
    chk("rejump_start", jump_start, 1);
    chk("rejump_h", height, 4);
    chk("rejump_h2", height2, 3);
    repeat (5) tick();
    chk("prepause_h", height, 24);
    chk("prepause_h2", height2, 18);

    @(negedge clk) enable = 1'b0;
    repeat (5) begin
      tick();
      chk("pause_h", height, 24);
      chk("pause_y", y_top, 64);
      chk("pause_start", jump_start, 0);
      chk("pause_land", landed, 0);
    end
    @(negedge clk) enable = 1'b1;
    tick();
    chk("resume_h", height, 28);
    chk("resume_h2", height2, 21);

    // Asynchronous reset mid-arc, no clock edge needed.
    @(negedge clk) resetn = 1'b0;
    #1;
    chk("midrst_h", height, 0);
    chk("midrst_y", y_top, 88);
    chk("midrst_gnd", ground, 1);
    chk("midrst_air", airborne, 0);
    chk("midrst_h2", height2, 0);
    @(negedge clk) resetn = 1'b1;
    idle(2);

    // Press edge lands in the same cycle as a ground tick.
    @(negedge clk) jump_key = 1'b0;
    @(negedge clk);
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    chk("race_h", height, 0);
    chk("race_start", jump_start, 0);
    chk("race_gnd", ground, 1);
    tick();
    chk("race_next_start", jump_start, 1);
    chk("race_next_h", height, 4);
    chk("race_next_air", airborne, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
